// File: rtl/regfile_pkg.sv
// Shared defaults and address helpers for the scoreboarded register file.
// Optional same-cycle write bypass is enabled with REGFILE_SB_BYPASS_EN.
package regfile_pkg;

   localparam int XLEN_DEF = 32;
   localparam int NREG_DEF = 32;

   // A two-entry file still needs one address bit.
   function automatic int addr_width(input int nreg);
      return (nreg <= 2) ? 1 : $clog2(nreg);
   endfunction

   typedef logic [addr_width(NREG_DEF)-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write bits: set at issue, cleared by either writeback port.
// A same-edge issue beats a same-edge clear; entry 0 never goes busy.
module regfile_scoreboard #(
   parameter int NREG = 32,
   parameter int AW   = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            set_en,
   input  logic [AW-1:0]   set_addr,
   input  logic            clr0_en,
   input  logic [AW-1:0]   clr0_addr,
   input  logic            clr1_en,
   input  logic [AW-1:0]   clr1_addr,
   output logic [NREG-1:0] busy_vec
);

   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_d;

   always_comb begin
      busy_d = busy_q;
      if (clr0_en) busy_d[clr0_addr] = 1'b0;
      if (clr1_en) busy_d[clr1_addr] = 1'b0;
      if (set_en)  busy_d[set_addr]  = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) busy_q <= '0;
      else     busy_q <= busy_d;
   end

   assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Register file with two write ports, NRD combinational read ports and a busy scoreboard.
// Define REGFILE_SB_BYPASS_EN to forward same-cycle writes to the read ports.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int NREG = NREG_DEF,
   parameter int NRD  = 2,
   localparam int AW  = addr_width(NREG)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NRD*AW-1:0] raddr,
   output logic [NRD*XLEN-1:0] rdata,
   output logic [NRD-1:0]    rbusy,
   input  logic              we0,
   input  logic [AW-1:0]     waddr0,
   input  logic [XLEN-1:0]   wdata0,
   input  logic              we1,
   input  logic [AW-1:0]     waddr1,
   input  logic [XLEN-1:0]   wdata1,
   input  logic              iss_valid,
   input  logic [AW-1:0]     iss_rd,
   output logic [NREG-1:0]   busy_vec,
   output logic              wcollide
);

   logic [XLEN-1:0] regs_q [NREG];
   logic [XLEN-1:0] regs_d [NREG];
   logic            wcollide_q;
   logic            wcollide_d;
   logic            wr0_en;
   logic            wr1_en;
   logic            iss_en;

   // Gating with rst keeps the combinational read path at zero while reset is held.
   assign wr0_en = we0 && (waddr0 != '0) && !rst;
   assign wr1_en = we1 && (waddr1 != '0) && !rst;
   assign iss_en = iss_valid && (iss_rd != '0) && !rst;

   always_comb begin
      regs_d = regs_q;
      if (wr0_en) regs_d[waddr0] = wdata0;
      if (wr1_en) regs_d[waddr1] = wdata1;
      regs_d[0] = '0;
      wcollide_d = wr0_en && wr1_en && (waddr0 == waddr1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
         wcollide_q <= 1'b0;
      end else begin
         regs_q     <= regs_d;
         wcollide_q <= wcollide_d;
      end
   end

   assign wcollide = wcollide_q;

   regfile_scoreboard #(.NREG(NREG), .AW(AW)) u_scoreboard (
      .clk       (clk),
      .rst       (rst),
      .set_en    (iss_en),
      .set_addr  (iss_rd),
      .clr0_en   (wr0_en),
      .clr0_addr (waddr0),
      .clr1_en   (wr1_en),
      .clr1_addr (waddr1),
      .busy_vec  (busy_vec)
   );

   genvar gi;
   generate
      for (gi = 0; gi < NRD; gi++) begin : g_rd
         logic [AW-1:0]   ra;
         logic [XLEN-1:0] rd_val;
         logic            rb_val;
         assign ra = raddr[gi*AW +: AW];
`ifdef REGFILE_SB_BYPASS_EN
         // Port 1 is checked first so it wins a same-address collision.
         always_comb begin
            rd_val = regs_q[ra];
            rb_val = busy_vec[ra];
            if (wr1_en && (waddr1 == ra)) begin
               rd_val = wdata1;
               rb_val = 1'b0;
            end else if (wr0_en && (waddr0 == ra)) begin
               rd_val = wdata0;
               rb_val = 1'b0;
            end
            if (iss_en && (iss_rd == ra)) rb_val = 1'b1;
            if (ra == '0) begin
               rd_val = '0;
               rb_val = 1'b0;
            end
         end
`else
         always_comb begin
            rd_val = (ra == '0) ? '0 : regs_q[ra];
            rb_val = busy_vec[ra];
         end
`endif
         assign rdata[gi*XLEN +: XLEN] = rd_val;
         assign rbusy[gi]              = rb_val;
      end
   endgenerate

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning the register data width in bits.
REQ-002 The block SHALL have parameter NREG, default 32, meaning the number of architectural registers; legal values are powers of two, 2 to 64.
REQ-003 The block SHALL have parameter NRD, default 2, meaning the number of read ports (1 to 4); AW = log2(NREG).
REQ-004 The block SHALL have these ports (name, direction, width, meaning):
  clk  in  1  clock, rising edge
  rst  in  1  reset, asynchronous, active-high
  raddr  in  NRD*AW  read addresses, port k in bits [k*AW +: AW]
  rdata  out  NRD*XLEN  read data, port k in bits [k*XLEN +: XLEN]
  rbusy  out  NRD  port k's register has a pending write
  we0 / waddr0 / wdata0  in  1 / AW / XLEN  write port 0 (ALU writeback)
  we1 / waddr1 / wdata1  in  1 / AW / XLEN  write port 1 (load writeback)
  iss_valid / iss_rd  in  1 / AW  issue marks iss_rd pending
  busy_vec  out  NREG  pending bit per register
  wcollide  out  1  registered flag: both write ports hit the same nonzero address

Function
REQ-005 Reads SHALL be combinational: rdata[k] = register raddr[k], zero-latency.
REQ-006 Register 0 SHALL always read 0, and writes to address 0 SHALL be ignored.
REQ-007 Writes SHALL commit on the rising clk edge when weN=1 and waddrN!=0.
REQ-008 If we0 and we1 target the same nonzero address in one cycle, port 1 SHALL win.
REQ-009 wcollide SHALL be 1 in the cycle after such a same-address write, otherwise 0.
REQ-010 iss_valid=1 with iss_rd!=0 SHALL set busy_vec[iss_rd] at the clock edge.
REQ-011 A committed write on either port SHALL clear busy_vec[waddr] at the clock edge.
REQ-012 When issue and write hit the same register in one cycle, the set SHALL win (busy stays 1, data still written).
REQ-013 busy_vec[0] SHALL always be 0.
REQ-014 rbusy[k] SHALL equal busy_vec[raddr[k]] as seen after that cycle's writes clear it.

Reset
REQ-015 While rst=1, all registers SHALL be 0, busy_vec SHALL be 0 and wcollide SHALL be 0, independent of clk.
REQ-016 Reset asserted mid-operation SHALL discard any same-edge write or issue.
REQ-017 After rst deasserts, the first clk edge SHALL act normally.

Configuration
REQ-018 With macro REGFILE_SB_BYPASS_EN defined, a read whose address matches a same-cycle committed write SHALL return that write data (port 1 priority) and rbusy[k] SHALL read 0 unless a same-cycle issue sets it.
REQ-019 Without REGFILE_SB_BYPASS_EN, reads SHALL return the pre-edge register contents and rbusy[k] SHALL reflect the pre-edge busy_vec.

Structure
REQ-020 Package regfile_pkg SHALL hold the XLEN/NREG defaults, the AW derivation function and the register-address typedef.
REQ-021 The busy-bit logic SHALL be a sub-module regfile_scoreboard (inputs: set, clear x2, rst; output: busy_vec).

Verification
REQ-022 Reset: rst=1 with arbitrary writes -> all rdata=0, busy_vec=0, wcollide=0.
REQ-023 Writing 0xDEADBEEF to x5 on port 0, then reading x5 the next cycle on ports 0 and 1 -> both return 0xDEADBEEF.
REQ-024 Writing 0x1234 to x0 on port 1 -> a read of x0 returns 0.
REQ-025 we0: x7=0x11 and we1: x7=0x22 in the same cycle -> x7=0x22, and wcollide=1 for one cycle.
REQ-026 Issue x9, then three idle cycles, then write x9=0x55 -> busy_vec[9]=1 for those cycles; the write clears it; with issue x9 on the same cycle as the write, busy_vec[9] stays 1.
REQ-027 With REGFILE_SB_BYPASS_EN, write x3=0xAA while raddr0=3 -> rdata0=0xAA in the same cycle; without the macro, rdata0 returns the old value.
